bcd3_7seg_scan: RTL and testbench

Time-multiplexed driver for a 3-digit common-anode 7-segment display, fed by the 8-bit binary-to-BCD converter (hundreds/tens/units).
- Captures a new BCD triple on a load strobe.
- Applies it only at frame boundaries, so no digit tearing.
- Scans the digits with a programmable dwell time and an anti-ghosting blank interval.
- Optionally suppresses leading zeros.

---
 rtl/bcd7seg_pkg.sv | 25 ++
 rtl/bcd_to_7seg.sv | 27 ++
 rtl/bcd3_7seg_scan.sv | 135 +++++++++++++
 tb/tb_bcd3_7seg_scan.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bcd7seg_pkg.sv
// Shared constants for the 3-digit multiplexed 7-segment driver.
// Segment patterns are active-high, bit order g..a (bit 0 = a).
package bcd7seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Scan order: units, tens, hundreds; value doubles as anode bit position
    typedef enum logic [1:0] {
        DIG_UNITS = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2
    } dig_idx_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-high 7-segment pattern; non-decimal codes show a dash.
module bcd_to_7seg
    import bcd7seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Pure lookup, codes 10..15 fall through to the dash
    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd3_7seg_scan.sv
// Time-multiplexed 3-digit common-anode display driver. A loaded BCD triple
// waits in a shadow register and is promoted only at frame end, so a frame
// never mixes digits from two values.
module bcd3_7seg_scan
    import bcd7seg_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       lzb_en,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]    AN_OFF    = AN_ACTIVE_LOW  ? 3'h7  : 3'h0;

    logic [CW-1:0] cnt_q, cnt_d;
    dig_idx_e      idx_q, idx_d;
    logic [11:0]   shadow_q, shadow_d;
    logic [11:0]   disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          fd_q, fd_d;

    logic          wrap, frame_end, lz_blank, off;
    logic [3:0]    cur_code;
    logic [6:0]    dec_seg, seg_hi;
    logic [2:0]    an_hi;

    assign wrap      = (cnt_q == CNT_LAST);
    assign frame_end = wrap && (idx_q == DIG_HUNDS);

    // Slot counter and digit index advance
    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (wrap) begin
            case (idx_q)
                DIG_UNITS: idx_d = DIG_TENS;
                DIG_TENS:  idx_d = DIG_HUNDS;
                default:   idx_d = DIG_UNITS;
            endcase
        end
    end

    // Shadow capture, and promotion to display only at frame end; a load in
    // the frame-end cycle itself bypasses the shadow so it is not lost
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        disp_d    = disp_q;
        if (load) begin
            shadow_d  = {bcd2, bcd1, bcd0};
            pending_d = 1'b1;
        end
        if (frame_end) begin
            if (load) begin
                disp_d    = {bcd2, bcd1, bcd0};
                pending_d = 1'b0;
            end else if (pending_q) begin
                disp_d    = shadow_q;
                pending_d = 1'b0;
            end
        end
    end

    // Digit select, blanking and polarity for the registered outputs
    always_comb begin
        case (idx_q)
            DIG_UNITS: cur_code = disp_q[3:0];
            DIG_TENS:  cur_code = disp_q[7:4];
            default:   cur_code = disp_q[11:8];
        endcase
        lz_blank = lzb_en && (((idx_q == DIG_HUNDS) && (disp_q[11:8] == 4'd0)) ||
                              ((idx_q == DIG_TENS)  && (disp_q[11:4] == 8'd0)));
        off      = (cnt_q < CNT_BLANK) || lz_blank;
        case (idx_q)
            DIG_UNITS: an_hi = 3'b001;
            DIG_TENS:  an_hi = 3'b010;
            default:   an_hi = 3'b100;
        endcase
        if (off) an_hi = 3'b000;
        seg_hi = off ? SEG_BLANK : dec_seg;
        seg_d  = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        an_d   = AN_ACTIVE_LOW  ? ~an_hi  : an_hi;
        fd_d   = frame_end;
    end

    bcd_to_7seg u_dec (
        .code (cur_code),
        .seg  (dec_seg)
    );

    // State and output registers, synchronous reset to idle/inactive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= DIG_UNITS;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd3_7seg_scan.sv
// Scoreboard bench: stimulus queues the expected content of each upcoming
// frame; the monitor pops one entry per frame_done and checks every cycle.
module tb_bcd3_7seg_scan;

    logic       clk = 1'b0;
    logic       rst_n, load, lzb_en;
    logic [3:0] bcd2, bcd1, bcd0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [6:0] su; logic [2:0] au;
        logic [6:0] st; logic [2:0] at;
        logic [6:0] sh; logic [2:0] ah;
    } frame_t;

    frame_t q[$];

    bcd3_7seg_scan #(
        .SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
        .lzb_en(lzb_en), .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Advance to the next negedge where frame_done is high (bounded)
    task automatic wait_fd();
        int n = 0;
        do begin @(negedge clk); n++; end while (!frame_done && n < 200);
        if (!frame_done) begin
            total++; bad++;
            $display("FAIL frame_done_timeout got=0 exp=1");
        end
    endtask

    task automatic push(input logic [6:0] su, input logic [2:0] au,
                        input logic [6:0] st, input logic [2:0] at,
                        input logic [6:0] sh, input logic [2:0] ah);
        frame_t f;
        f.su = su; f.au = au; f.st = st; f.at = at; f.sh = sh; f.ah = ah;
        q.push_back(f);
    endtask

    // Load sampled on the posedge following k more negedges
    task automatic ld(input int k, input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        repeat (k) @(negedge clk);
        bcd2 = h; bcd1 = t; bcd0 = u; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Monitor: checks the 24 cycles of each frame that has an expectation
    initial begin
        frame_t e;
        logic [6:0] es;
        logic [2:0] ea;
        wait_fd();
        forever begin
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int j = 0; j < 23; j++) begin
                    @(negedge clk);
                    if (j % 8 < 2) begin
                        es = 7'h7F; ea = 3'b111;
                    end else if (j < 8) begin
                        es = e.su; ea = e.au;
                    end else if (j < 16) begin
                        es = e.st; ea = e.at;
                    end else begin
                        es = e.sh; ea = e.ah;
                    end
                    chk($sformatf("seg_c%0d", j), {1'b0, seg}, {1'b0, es});
                    chk($sformatf("an_c%0d", j), {5'b0, an}, {5'b0, ea});
                    chk($sformatf("fd_c%0d", j), {7'b0, frame_done}, 8'd0);
                end
                @(negedge clk);
                chk("fd_period", {7'b0, frame_done}, 8'd1);
            end else begin
                @(negedge clk);
                wait_fd();
            end
        end
    end

    // Stimulus
    initial begin
        rst_n = 1'b0; load = 1'b0; lzb_en = 1'b0;
        bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_an", {5'b0, an}, 8'h07);
        chk("rst_fd", {7'b0, frame_done}, 8'h00);
        push(7'h40, 3'b110, 7'h40, 3'b101, 7'h40, 3'b011);
        rst_n = 1'b1;

        // b1: idle frame of zeros again
        wait_fd(); #1;
        push(7'h40, 3'b110, 7'h40, 3'b101, 7'h40, 3'b011);
        // b2: load 255 mid-frame, shown from next frame
        wait_fd(); #1;
        push(7'h12, 3'b110, 7'h12, 3'b101, 7'h24, 3'b011);
        ld(10, 4'd2, 4'd5, 4'd5);
        // b3: load 007, next frame with leading-zero blanking
        wait_fd(); #1;
        push(7'h78, 3'b110, 7'h7F, 3'b111, 7'h7F, 3'b111);
        ld(5, 4'd0, 4'd0, 4'd7);
        // b4: blanking on for this frame, off for the next
        wait_fd(); #1;
        lzb_en = 1'b1;
        push(7'h78, 3'b110, 7'h40, 3'b101, 7'h40, 3'b011);
        // b5: three loads, last on the frame-end cycle
        wait_fd(); #1;
        lzb_en = 1'b0;
        push(7'h30, 3'b110, 7'h30, 3'b101, 7'h30, 3'b011);
        ld(3, 4'd0, 4'd0, 4'd9);
        ld(8, 4'd1, 4'd4, 4'd0);
        ld(10, 4'd3, 4'd3, 4'd3);
        // now at b6: nothing pending, 333 must stay
        #1;
        push(7'h30, 3'b110, 7'h30, 3'b101, 7'h30, 3'b011);
        // b7: dash code on units
        wait_fd(); #1;
        push(7'h3F, 3'b110, 7'h30, 3'b101, 7'h30, 3'b011);
        ld(4, 4'd3, 4'd3, 4'hC);
        wait_fd(); #1;
        // b9: reset during a display interval with a load pending
        wait_fd(); #1;
        ld(2, 4'd9, 4'd9, 4'd9);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_seg", {1'b0, seg}, 8'h7F);
        chk("midrst_an", {5'b0, an}, 8'h07);
        chk("midrst_fd", {7'b0, frame_done}, 8'h00);
        push(7'h40, 3'b110, 7'h40, 3'b101, 7'h40, 3'b011);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_fd();
        wait_fd();
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
